park_allocator: RTL

PARK_ALLOCATOR -- requirements
Module: park_allocator

---
 rtl/park_allocator.sv | 117 +++++++++++
 1 files changed

// File: rtl/park_allocator.sv
// Eight-slot parking allocator: grants the lowest free slot and tags it with an LFSR pattern,
// then validates exits by checking token == slot ^ stored pattern before freeing the slot.
//
// state | meaning
// IDLE  | waiting for a request; exit wins over enter
// ALLOC | grant lowest free slot, or deny when the lot is full
// CHECK | validate latched exit slot/token, free the slot or reject
// DONE  | hold until both requests drop so a held request is served once
module park_allocator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enter_req,
  input  logic       exit_req,
  input  logic [2:0] exit_slot,
  input  logic [2:0] exit_token,
  output logic [2:0] park_number,
  output logic [2:0] pattern,
  output logic       grant,
  output logic       deny,
  output logic       exit_ok,
  output logic       exit_err,
  output logic [7:0] occupancy,
  output logic [3:0] free_count,
  output logic       full,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ALLOC, CHECK, DONE} state_t;

  state_t     state;
  logic [2:0] lfsr;
  logic [2:0] pattern_mem [8];
  logic [2:0] slot_q;
  logic [2:0] token_q;
  logic [2:0] free_slot;
  logic [3:0] ones;
  logic       token_match;

  always_comb begin
    free_slot = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!occupancy[i]) free_slot = 3'(i);
    end
  end

  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'b000, occupancy[i]};
    end
  end

  assign free_count  = 4'd8 - ones;
  assign full        = &occupancy;
  assign busy        = (state != IDLE);
  assign token_match = occupancy[slot_q] && (token_q == (slot_q ^ pattern_mem[slot_q]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lfsr        <= 3'b001;
      occupancy   <= 8'h00;
      park_number <= 3'd0;
      pattern     <= 3'd0;
      slot_q      <= 3'd0;
      token_q     <= 3'd0;
      grant       <= 1'b0;
      deny        <= 1'b0;
      exit_ok     <= 1'b0;
      exit_err    <= 1'b0;
      for (int i = 0; i < 8; i++) pattern_mem[i] <= 3'd0;
    end else begin
      lfsr     <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
      grant    <= 1'b0;
      deny     <= 1'b0;
      exit_ok  <= 1'b0;
      exit_err <= 1'b0;
      case (state)
        IDLE: begin
          if (exit_req) begin
            slot_q  <= exit_slot;
            token_q <= exit_token;
            state   <= CHECK;
          end else if (enter_req) begin
            state <= ALLOC;
          end
        end
        ALLOC: begin
          if (!full) begin
            occupancy[free_slot]   <= 1'b1;
            pattern_mem[free_slot] <= lfsr;
            park_number            <= free_slot;
            pattern                <= lfsr;
            grant                  <= 1'b1;
          end else begin
            deny <= 1'b1;
          end
          state <= DONE;
        end
        CHECK: begin
          if (token_match) begin
            occupancy[slot_q] <= 1'b0;
            exit_ok           <= 1'b1;
          end else begin
            exit_err <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          if (!enter_req && !exit_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
